// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_DRAIN    = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    // Zero register: reads as zero, so it never carries a dependency.
    localparam logic [4:0] c_xzr            = 5'd31;
    localparam int         c_perf_w_default = 32;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Event counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              clear,
    output logic [PERF_W-1:0] count
);

    logic [PERF_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != {PERF_W{1'b1}})) begin
            r_count <= r_count + PERF_W'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush sequencer for the 5-stage pipeline (drain after
//               reset, memory freeze, load-use bubble, taken-branch flush).
//               Optional performance counters: define HAZARD_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int MEM_TIMEOUT  = 255,
    parameter int PERF_W       = c_perf_w_default
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        id_rn,
    input  logic [4:0]        id_rm,
    input  logic              id_uses_rn,
    input  logic              id_uses_rm,
    input  logic              idex_mem_read,
    input  logic [4:0]        idex_rd,
    input  logic              branch_taken,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              memwb_bubble,
    output logic              mem_timeout,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt,
    output logic [PERF_W-1:0] memwait_cnt
);

    localparam int c_drain_w = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int c_wait_w  = $clog2(MEM_TIMEOUT + 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [c_drain_w-1:0]  r_drain_cnt;
    logic [c_wait_w-1:0]   r_wait_cnt;
    logic [c_wait_w-1:0]   w_wait_inc;
    logic                  r_mem_timeout;
    logic                  w_freeze;
    logic                  w_load_use;
    logic                  w_stall_inc;
    logic                  w_flush_inc;
    logic                  w_memwait_inc;

    assign w_freeze   = dmem_req & ~dmem_ready;
    assign w_load_use = idex_mem_read & (idex_rd != c_xzr) &
                        ((id_uses_rn & (id_rn == idex_rd)) |
                         (id_uses_rm & (id_rm == idex_rd)));
    assign w_wait_inc = r_wait_cnt + c_wait_w'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_DRAIN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drain_cnt   <= '0;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            if (r_state == ST_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + c_drain_w'(1);
            end
            // First frozen cycle restarts the count; later ones advance it.
            if ((r_state == ST_RUN) && w_freeze) begin
                r_wait_cnt <= '0;
            end else if ((r_state == ST_MEM_WAIT) && w_freeze &&
                         (r_wait_cnt != c_wait_w'(MEM_TIMEOUT))) begin
                r_wait_cnt <= w_wait_inc;
                if (w_wait_inc == c_wait_w'(MEM_TIMEOUT)) begin
                    r_mem_timeout <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        memwb_en      = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        memwb_bubble  = 1'b0;
        w_stall_inc   = 1'b0;
        w_flush_inc   = 1'b0;
        w_memwait_inc = 1'b0;

        case (r_state)
            ST_RUN, ST_MEM_WAIT: begin
                if (w_freeze) begin
                    // Hold everything upstream of MEM; WB receives a bubble.
                    pc_en         = 1'b0;
                    ifid_en       = 1'b0;
                    idex_en       = 1'b0;
                    exmem_en      = 1'b0;
                    memwb_bubble  = 1'b1;
                    w_memwait_inc = 1'b1;
                    w_state_next  = ST_MEM_WAIT;
                end else begin
                    w_state_next = ST_RUN;
                    if (w_load_use) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                        w_stall_inc = 1'b1;
                    end else if (branch_taken) begin
                        ifid_flush  = 1'b1;
                        w_flush_inc = 1'b1;
                    end
                end
            end
            default: begin
                pc_en        = 1'b0;
                ifid_flush   = 1'b1;
                idex_bubble  = 1'b1;
                memwb_bubble = 1'b1;
                if ((r_state == ST_DRAIN) &&
                    (r_drain_cnt == c_drain_w'(DRAIN_CYCLES - 1))) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
        endcase
    end

    assign mem_timeout = r_mem_timeout;

`ifdef HAZARD_PERF_CNT_EN
    sat_counter #(.PERF_W(PERF_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall_inc),
        .clear (1'b0),
        .count (stall_cnt)
    );

    sat_counter #(.PERF_W(PERF_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_flush_inc),
        .clear (1'b0),
        .count (flush_cnt)
    );

    sat_counter #(.PERF_W(PERF_W)) u_memwait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_memwait_inc),
        .clear (1'b0),
        .count (memwait_cnt)
    );
`else
    logic w_unused_perf;
    assign w_unused_perf = w_stall_inc ^ w_flush_inc ^ w_memwait_inc;
    assign stall_cnt     = '0;
    assign flush_cnt     = '0;
    assign memwait_cnt   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Scoreboard bench for pipeline_hazard_ctrl (DRAIN=4, TIMEOUT=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int c_perf_w = 32;
`ifdef HAZARD_PERF_CNT_EN
    localparam int c_perf_on = 1;
`else
    localparam int c_perf_on = 0;
`endif

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble, memwb_bubble}
    localparam logic [7:0] c_e_drain = 8'b0111_1111;
    localparam logic [7:0] c_e_run   = 8'b1111_1000;
    localparam logic [7:0] c_e_frz   = 8'b0000_1001;
    localparam logic [7:0] c_e_lu    = 8'b0011_1010;
    localparam logic [7:0] c_e_fl    = 8'b1111_1100;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [4:0] id_rn = '0, id_rm = '0, idex_rd = '0;
    logic id_uses_rn = 1'b0, id_uses_rm = 1'b0, idex_mem_read = 1'b0;
    logic branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_bubble, memwb_bubble, mem_timeout;
    logic [c_perf_w-1:0] stall_cnt, flush_cnt, memwait_cnt;

    typedef struct {
        logic [7:0] outs;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .DRAIN_CYCLES (4),
        .MEM_TIMEOUT  (8),
        .PERF_W       (c_perf_w)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .id_rn         (id_rn),
        .id_rm         (id_rm),
        .id_uses_rn    (id_uses_rn),
        .id_uses_rm    (id_uses_rm),
        .idex_mem_read (idex_mem_read),
        .idex_rd       (idex_rd),
        .branch_taken  (branch_taken),
        .dmem_req      (dmem_req),
        .dmem_ready    (dmem_ready),
        .pc_en         (pc_en),
        .ifid_en       (ifid_en),
        .idex_en       (idex_en),
        .exmem_en      (exmem_en),
        .memwb_en      (memwb_en),
        .ifid_flush    (ifid_flush),
        .idex_bubble   (idex_bubble),
        .memwb_bubble  (memwb_bubble),
        .mem_timeout   (mem_timeout),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt),
        .memwait_cnt   (memwait_cnt)
    );

    wire [7:0] w_obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                        ifid_flush, idex_bubble, memwb_bubble};

    // Scoreboard consumer: one expected control vector per driven cycle.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (w_obs !== e.outs) begin
                bad++;
                $display("FAIL %s: got %b want %b", e.tag, w_obs, e.outs);
            end
        end
    end

    task automatic drive(input logic rst, input logic mr, input logic [4:0] rd,
                         input logic [4:0] rn, input logic urn,
                         input logic [4:0] rm, input logic urm,
                         input logic br, input logic req, input logic rdy,
                         input logic [7:0] e, input string tag);
        exp_t x;
        @(negedge clk);
        reset = rst; idex_mem_read = mr; idex_rd = rd;
        id_rn = rn; id_uses_rn = urn; id_rm = rm; id_uses_rm = urm;
        branch_taken = br; dmem_req = req; dmem_ready = rdy;
        x.outs = e;
        x.tag  = tag;
        exp_q.push_back(x);
    endtask

    task automatic idle(input logic [7:0] e, input string tag);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, e, tag);
    endtask

    task automatic test_reset;
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_e_drain, "rst_hold0");
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_e_drain, "rst_hold1");
        #3;
        total++;
        if ({mem_timeout, stall_cnt, flush_cnt, memwait_cnt} !== '0) begin
            bad++;
            $display("FAIL rst_regs: got to=%b s=%0d f=%0d m=%0d want all 0",
                     mem_timeout, stall_cnt, flush_cnt, memwait_cnt);
        end
        for (int i = 0; i < 4; i++) idle(c_e_drain, "drain");
        idle(c_e_run, "drain_exit_run");
        idle(c_e_run, "run_idle");
    endtask

    task automatic test_load_use;
        drive(1'b0, 1'b1, 5'd3, 5'd5, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, c_e_lu, "lu_rm");
        idle(c_e_run, "lu_rm_release");
        drive(1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, c_e_lu, "lu_rn");
        drive(1'b0, 1'b0, 5'd7, 5'd7, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, c_e_run, "lu_rn_release");
    endtask

    task automatic test_xzr_and_unused;
        drive(1'b0, 1'b1, 5'd31, 5'd31, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, c_e_run, "xzr");
        drive(1'b0, 1'b1, 5'd3, 5'd3, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, c_e_run, "unused_src");
        drive(1'b0, 1'b0, 5'd3, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, c_e_run, "not_load");
    endtask

    task automatic test_freeze;
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, c_e_frz, "frz1");
        drive(1'b0, 1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, c_e_frz, "frz2_over_lu_br");
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, c_e_frz, "frz3");
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, c_e_run, "frz_ready");
        idle(c_e_run, "frz_after");
        #3;
        total++;
        if (memwait_cnt !== c_perf_w'(3 * c_perf_on)) begin
            bad++;
            $display("FAIL memwait_cnt: got %0d want %0d", memwait_cnt, 3 * c_perf_on);
        end
        total++;
        if (stall_cnt !== c_perf_w'(2 * c_perf_on)) begin
            bad++;
            $display("FAIL stall_cnt_frz: got %0d want %0d", stall_cnt, 2 * c_perf_on);
        end
        total++;
        if (mem_timeout !== 1'b0) begin
            bad++;
            $display("FAIL short_wait_timeout: got %b want 0", mem_timeout);
        end
    endtask

    task automatic test_branch_under_stall;
        drive(1'b0, 1'b1, 5'd6, 5'd6, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, c_e_lu, "br_lu_stall");
        drive(1'b0, 1'b0, 5'd6, 5'd6, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, c_e_fl, "br_flush");
        idle(c_e_run, "br_after");
        #3;
        total++;
        if (flush_cnt !== c_perf_w'(c_perf_on)) begin
            bad++;
            $display("FAIL flush_cnt: got %0d want %0d", flush_cnt, c_perf_on);
        end
        total++;
        if (stall_cnt !== c_perf_w'(3 * c_perf_on)) begin
            bad++;
            $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, 3 * c_perf_on);
        end
    endtask

    task automatic test_timeout;
        for (int i = 1; i <= 11; i++) begin
            drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, c_e_frz, "to_frz");
            #3;
            total++;
            if (mem_timeout !== ((i >= 10) ? 1'b1 : 1'b0)) begin
                bad++;
                $display("FAIL timeout_cyc%0d: got %b want %b", i, mem_timeout, (i >= 10));
            end
        end
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, c_e_run, "to_release");
        idle(c_e_run, "to_idle");
        #3;
        total++;
        if (mem_timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky: got %b want 1", mem_timeout);
        end
        total++;
        if (memwait_cnt !== c_perf_w'(14 * c_perf_on)) begin
            bad++;
            $display("FAIL memwait_total: got %0d want %0d", memwait_cnt, 14 * c_perf_on);
        end
    endtask

    task automatic test_reset_mid;
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, c_e_frz, "mid_frz");
        #3;
        reset = 1'b1;
        #1;
        total++;
        if (w_obs !== c_e_drain) begin
            bad++;
            $display("FAIL mid_reset_outs: got %b want %b", w_obs, c_e_drain);
        end
        total++;
        if ({mem_timeout, stall_cnt, flush_cnt, memwait_cnt} !== '0) begin
            bad++;
            $display("FAIL mid_reset_regs: got to=%b s=%0d f=%0d m=%0d want all 0",
                     mem_timeout, stall_cnt, flush_cnt, memwait_cnt);
        end
        for (int i = 0; i < 4; i++) idle(c_e_drain, "redrain");
        idle(c_e_run, "redrain_exit");
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_xzr_and_unused();
        test_freeze();
        test_branch_under_stall();
        test_timeout();
        test_reset_mid();
        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
